// File: rtl/rs_trace_buffer.sv
// rs_trace_buffer: multi-channel register-index trace capture.
// Circular buffer that freezes after a trigger and post-trigger window, then drains.
module rs_trace_buffer #(
  parameter int NUM_CH   = 2,
  parameter int IDX_W    = 5,
  parameter int DEPTH    = 16,
  parameter int POST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_valid,
  input  logic [NUM_CH*IDX_W-1:0]     rs_idx,
  input  logic                        arm,
  input  logic                        abort,
  input  logic                        trig_en,
  input  logic [IDX_W-1:0]            trig_idx,
  input  logic                        rd_ready,
  output logic                        rd_valid,
  output logic [NUM_CH*IDX_W-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        busy,
  output logic                        done,
  output logic                        triggered,
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = NUM_CH * IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [AW-1:0]   r_post_cnt;
  logic            r_triggered;
  logic            r_overflow;

  logic            w_match;
  logic            w_full;
  logic            w_wr;
  logic            w_pop;

  // any channel carrying the trigger index
  always_comb begin
    w_match = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rs_idx[c*IDX_W +: IDX_W] == trig_idx) w_match = 1'b1;
    end
  end

  assign w_full = (r_level == LW'(DEPTH));
  assign w_wr   = sample_valid && !abort &&
                  (r_state == S_ARMED || r_state == S_POST);
  assign w_pop  = rd_valid && rd_ready;

  // sample storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= rs_idx;
  end

  // capture/readout state machine with pointers and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_post_cnt  <= '0;
      r_triggered <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (arm && !abort) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_state     <= S_ARMED;
          end
        end
        S_ARMED, S_POST: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_level <= '0;
          end else if (sample_valid) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_full) begin
              r_rd_ptr   <= r_rd_ptr + AW'(1);
              r_overflow <= 1'b1;
            end else begin
              r_level <= r_level + LW'(1);
            end
            if (r_state == S_ARMED) begin
              if (trig_en && w_match) begin
                r_triggered <= 1'b1;
                if (POST_LEN == 0) begin
                  r_state <= S_DONE;
                end else begin
                  r_state    <= S_POST;
                  r_post_cnt <= AW'(POST_LEN);
                end
              end
            end else begin
              r_post_cnt <= r_post_cnt - AW'(1);
              if (r_post_cnt == AW'(1)) r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_level <= '0;
          end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level  <= r_level - LW'(1);
            if (r_level == LW'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_ARMED) || (r_state == S_POST);
  assign done      = (r_state == S_DONE);
  assign rd_valid  = done && (r_level != '0);
  assign rd_data   = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign triggered = r_triggered;
  assign overflow  = r_overflow;

endmodule

// File: doc/rs_trace_buffer.md
Name: rs_trace_buffer

Overview:
- Parametrised debug trace buffer for the riscv core: captures the per-cycle register-source indices (Rs1, Rs2, ... NUM_CH channels) into a circular buffer.
- Freezes a programmable number of samples after a trigger index is seen on any channel, then allows pop-style readout by the bench or debug logic.
- Generalises the current bench-level Rs1/Rs2 observation into synthesizable, multi-channel, triggerable capture.

Parameters:
- NUM_CH, 2, number of register-index channels sampled per cycle (>=1)
- IDX_W, 5, width of each register index
- DEPTH, 16, buffer entries; power of 2, >=4
- POST_LEN, 4, samples captured after the trigger sample; 0 <= POST_LEN < DEPTH

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- sample_valid  in  1  rs_idx is valid this cycle
- rs_idx  in  NUM_CH*IDX_W  channel c at bits [c*IDX_W +: IDX_W]; channel 0 = Rs1 in LSBs
- arm  in  1  pulse: start capture (honoured only in IDLE)
- abort  in  1  pulse: discard capture, return to IDLE
- trig_en  in  1  enables trigger matching
- trig_idx  in  IDX_W  index that triggers
- rd_ready  in  1  consumer accepts rd_data
- rd_valid  out  1  rd_data holds oldest unread entry
- rd_data  out  NUM_CH*IDX_W  oldest entry, same packing as rs_idx
- level  out  $clog2(DEPTH)+1  entries held
- busy  out  1  state is ARMED or POST
- done  out  1  state is DONE
- triggered  out  1  sticky: trigger seen since last arm
- overflow  out  1  sticky: oldest entry overwritten since last arm

Behaviour:
- All state updates on rising clk. Synchronous reset (any state, including mid-readout) forces:
  - state IDLE
  - wr_ptr, rd_ptr, level all 0
  - triggered, overflow, busy, done, rd_valid all 0
  - Buffer contents need not be cleared.
- States: IDLE, ARMED, POST, DONE.
- IDLE:
  - sample_valid ignored.
  - arm=1 and abort=0: clear ptrs, level, triggered and overflow; go ARMED next cycle.
- ARMED, on sample_valid=1:
  - Write rs_idx at wr_ptr; wr_ptr increments mod DEPTH.
  - If level==DEPTH: rd_ptr advances too (oldest dropped), level stays DEPTH, overflow set. Otherwise level+1.
  - Trigger when trig_en=1 and any channel equals trig_idx on a valid sample. The trigger sample itself is written; triggered set.
  - After trigger: go POST with post_cnt=POST_LEN, or go DONE directly if POST_LEN==0.
  - sample_valid=0: no write, no trigger.
- POST:
  - Each valid sample is written with the same overwrite rule; trigger matching disabled; post_cnt decrements.
  - The write that takes post_cnt to 0 moves the block to DONE next cycle.
- DONE:
  - No writes.
  - rd_valid = (level != 0); rd_data = mem[rd_ptr], combinational from registered storage.
  - On rd_valid & rd_ready: rd_ptr+1 mod DEPTH, level-1.
  - The pop that empties the buffer moves the block to IDLE next cycle; triggered and overflow remain until next arm.
- rd_valid is 0 outside DONE; rd_ready is ignored outside DONE.
- abort=1 in ARMED/POST/DONE: next state IDLE, level=0, rd_valid=0. abort wins over arm, trigger and pop in the same cycle.
- arm in ARMED/POST/DONE is ignored.
- busy and done decode directly from registered state.

Test Plan (NUM_CH=2, IDX_W=5, DEPTH=8, POST_LEN=2):
- Basic capture:
  - Stimulus: reset, arm, trig_en=1, trig_idx=5; samples (rs1,rs2)=(1,2),(3,4),(5,6),(7,8),(9,10).
  - Required: trigger on (5,6); done after (9,10); level=5, overflow=0; readout with rd_ready=1 yields (1,2),(3,4),(5,6),(7,8),(9,10); IDLE next cycle.
- Wrap/overflow:
  - Stimulus: 12 non-matching samples s1..s12, trigger s13, then s14, s15.
  - Required: level=8, overflow=1, readout s8..s15 in order.
- Channel-1 match and gating:
  - Stimulus: trig_idx=7, sample (0,7) with sample_valid=0, then (0,7) with sample_valid=1.
  - Required: only the second triggers; level=1 at trigger.
- trig_en=0:
  - Stimulus: 20 samples containing trig_idx.
  - Required: stays ARMED, busy=1, triggered=0, level=8.
- Abort/arm priority:
  - Stimulus: abort during POST.
  - Required: IDLE next cycle, level=0, rd_valid=0.
  - Stimulus: arm+abort together in IDLE.
  - Required: stays IDLE.
- Reset mid-readout:
  - Stimulus: assert reset after 2 pops in DONE.
  - Required: all outputs 0, state IDLE next cycle.
